// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one 8-bit ALU between two requesters.
// Accepts one op, holds the ALU inputs for SETTLE_CYCLES, captures RESULT/ZERO and returns it.
module alu_share_arbiter #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  REQ_VALID,
    output logic [1:0]  REQ_READY,
    input  logic [5:0]  REQ_OPCODE,
    input  logic [15:0] REQ_OPA,
    input  logic [15:0] REQ_OPB,
    input  logic [7:0]  REQ_SHAMT,
    input  logic [1:0]  REQ_DIR,
    output logic [1:0]  RSP_VALID,
    input  logic [1:0]  RSP_READY,
    output logic [7:0]  RSP_RESULT,
    output logic        RSP_ZERO,
    output logic [2:0]  ALU_SELECT,
    output logic [7:0]  ALU_DATA1,
    output logic [7:0]  ALU_DATA2,
    output logic [3:0]  ALU_SHIFT,
    output logic        ALU_CHOICE,
    input  logic [7:0]  ALU_RESULT,
    input  logic        ALU_ZERO,
    output logic        BUSY,
    output logic        GRANT_ID
);

    localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] shamt;
        logic       dir;
    } req_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic           grant_q;
    logic           winner;
    logic           accept;
    req_t           req [2];
    req_t           win_req;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign req[gi] = '{op:    REQ_OPCODE[gi*3 +: 3],
                               a:     REQ_OPA[gi*8 +: 8],
                               b:     REQ_OPB[gi*8 +: 8],
                               shamt: REQ_SHAMT[gi*4 +: 4],
                               dir:   REQ_DIR[gi]};
        end
    endgenerate

    // On a tie the requester not served last wins; a lone requester always wins.
    assign winner  = (&REQ_VALID) ? ~grant_q : REQ_VALID[1];
    assign win_req = req[winner];

    always_comb begin
        state_nxt = state;
        REQ_READY = 2'b00;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (|REQ_VALID) begin
                    REQ_READY[winner] = 1'b1;
                    accept            = 1'b1;
                    state_nxt         = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt == CW'(1))
                    state_nxt = S_RESP;
            end
            S_RESP: begin
                if (RSP_READY[grant_q])
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= S_IDLE;
            cnt        <= '0;
            grant_q    <= 1'b1;
            RSP_RESULT <= 8'h00;
            RSP_ZERO   <= 1'b0;
            ALU_SELECT <= 3'b000;
            ALU_DATA1  <= 8'h00;
            ALU_DATA2  <= 8'h00;
            ALU_SHIFT  <= 4'h0;
            ALU_CHOICE <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ALU_SELECT <= win_req.op;
                ALU_DATA1  <= win_req.a;
                ALU_DATA2  <= win_req.b;
                ALU_SHIFT  <= win_req.shamt;
                ALU_CHOICE <= win_req.dir;
                grant_q    <= winner;
                cnt        <= CW'(SETTLE_CYCLES);
            end
            if (state == S_BUSY) begin
                cnt <= cnt - CW'(1);
                // Last settle cycle: ALU outputs have been stable long enough to capture.
                if (cnt == CW'(1)) begin
                    RSP_RESULT <= ALU_RESULT;
                    RSP_ZERO   <= ALU_ZERO;
                end
            end
        end
    end

    assign RSP_VALID = (state == S_RESP) ? (2'b01 << grant_q) : 2'b00;
    assign BUSY      = (state != S_IDLE);
    assign GRANT_ID  = grant_q;

endmodule
